// File: rtl/serial_out_frame_sequencer.sv
// Generates the FREQ + per-channel DATA byte packets that program diff_freq_serial_out,
// standing in for the UART receiver on the decoder's data/rx_done_tick inputs.

module serial_out_frame_sequencer_chan #(
  parameter int DATA_BIT = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                i_we,
  input  logic [DATA_BIT-1:0] i_pattern,
  input  logic [2:0]          i_ctrl,
  output logic [DATA_BIT-1:0] o_pattern,
  output logic [2:0]          o_ctrl
);
  logic [DATA_BIT-1:0] r_pattern;
  logic [2:0]          r_ctrl;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pattern <= '0;
      r_ctrl    <= '0;
    end else if (i_we) begin
      r_pattern <= i_pattern;
      r_ctrl    <= i_ctrl;
    end
  end

  assign o_pattern = r_pattern;
  assign o_ctrl    = r_ctrl;
endmodule

module serial_out_frame_sequencer #(
  parameter int DATA_BIT   = 32,
  parameter int PACK_NUM   = 9,
  parameter int OUTPUT_NUM = 16,
  parameter int BYTE_GAP   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_we_i,
  input  logic [3:0]          cfg_addr_i,
  input  logic [DATA_BIT-1:0] cfg_pattern_i,
  input  logic [2:0]          cfg_ctrl_i,
  input  logic                freq_we_i,
  input  logic [DATA_BIT-1:0] freq_pattern_i,
  input  logic [7:0]          slow_period_i,
  input  logic [7:0]          fast_period_i,
  input  logic                frame_start_i,
  output logic                busy_o,
  output logic                frame_done_tick_o,
  output logic [7:0]          data_o,
  output logic                tick_o
);
  localparam int PKT_W    = PACK_NUM * 8;
  localparam int BC_W     = $clog2(PACK_NUM + 1);
  localparam int PI_W     = $clog2(OUTPUT_NUM + 1);
  localparam int GAP_LAST = (BYTE_GAP > 1) ? BYTE_GAP - 2 : 0;
  localparam int GAP_W    = (BYTE_GAP > 2) ? $clog2(BYTE_GAP - 1) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_GAP, S_DONE} state_t;

  state_t                              r_state, w_nxt;
  logic [OUTPUT_NUM-1:0][DATA_BIT-1:0] w_pat;
  logic [OUTPUT_NUM-1:0][2:0]          w_ctrl;
  logic [DATA_BIT-1:0]                 r_freq;
  logic [7:0]                          r_slow, r_fast;
  logic [PKT_W-1:0]                    r_shift, w_pkt;
  logic [BC_W-1:0]                     r_bcnt;
  logic [PI_W-1:0]                     r_pkt_idx;
  logic [GAP_W-1:0]                    r_gap;
  logic [7:0]                          r_last, w_byte;
  logic                                r_pend;
  logic [3:0]                          w_ch;
  logic                                w_go, w_last_byte, w_last_pkt;

  for (genvar g = 0; g < OUTPUT_NUM; g++) begin : gen_chan
    serial_out_frame_sequencer_chan #(.DATA_BIT(DATA_BIT)) u_chan (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .i_we      (cfg_we_i && (cfg_addr_i == 4'(g))),
      .i_pattern (cfg_pattern_i),
      .i_ctrl    (cfg_ctrl_i),
      .o_pattern (w_pat[g]),
      .o_ctrl    (w_ctrl[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_freq <= '0;
      r_slow <= 8'd20;
      r_fast <= 8'd5;
    end else if (freq_we_i) begin
      r_freq <= freq_pattern_i;
      r_slow <= slow_period_i;
      r_fast <= fast_period_i;
    end
  end

  // Packet 0 is FREQ; packet k>0 carries channel k-1.
  assign w_ch = 4'(r_pkt_idx - PI_W'(1));

  always_comb begin
    w_pkt = '0;
    if (r_pkt_idx == '0) begin
      w_pkt[PKT_W-1 -: 8]              = 8'h0A;
      w_pkt[PKT_W-9 -: DATA_BIT]       = r_freq;
      w_pkt[PKT_W-9-DATA_BIT -: 8]     = r_slow;
      w_pkt[PKT_W-17-DATA_BIT -: 8]    = r_fast;
    end else begin
      w_pkt[PKT_W-1 -: 8]              = 8'h0B;
      w_pkt[PKT_W-9 -: DATA_BIT]       = w_pat[w_ch];
      w_pkt[PKT_W-9-DATA_BIT -: 8]     = {w_ch, w_ctrl[w_ch], 1'b0};
    end
  end

  assign w_byte      = r_shift[PKT_W-1 -: 8];
  assign w_last_byte = (r_bcnt == BC_W'(PACK_NUM - 1));
  assign w_last_pkt  = (r_pkt_idx == PI_W'(OUTPUT_NUM));
  assign w_go        = frame_start_i || r_pend;

  always_comb begin
    w_nxt             = r_state;
    tick_o            = 1'b0;
    frame_done_tick_o = 1'b0;
    case (r_state)
      S_IDLE: if (w_go) w_nxt = S_LOAD;
      S_LOAD: w_nxt = S_SEND;
      S_SEND: begin
        tick_o = 1'b1;
        if (w_last_byte && w_last_pkt) w_nxt = S_DONE;
        else if (BYTE_GAP > 1)         w_nxt = S_GAP;
        else                           w_nxt = w_last_byte ? S_LOAD : S_SEND;
      end
      // Gap after the last byte leads to LOAD so inter-packet spacing is BYTE_GAP+1.
      S_GAP: if (r_gap == GAP_W'(GAP_LAST))
        w_nxt = (r_bcnt == BC_W'(PACK_NUM)) ? S_LOAD : S_SEND;
      S_DONE: begin
        frame_done_tick_o = 1'b1;
        w_nxt = w_go ? S_LOAD : S_IDLE;
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bcnt    <= '0;
      r_pkt_idx <= '0;
      r_gap     <= '0;
      r_last    <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if ((r_state == S_IDLE || r_state == S_DONE) && w_go) begin
        r_pend    <= 1'b0;
        r_pkt_idx <= '0;
      end else if (frame_start_i && r_state != S_IDLE) begin
        r_pend <= 1'b1;
      end
      case (r_state)
        S_LOAD: begin
          r_shift <= w_pkt;
          r_bcnt  <= '0;
        end
        S_SEND: begin
          r_last  <= w_byte;
          r_shift <= {r_shift[PKT_W-9:0], 8'h00};
          r_bcnt  <= r_bcnt + BC_W'(1);
          r_gap   <= '0;
          if (w_last_byte && !w_last_pkt) r_pkt_idx <= r_pkt_idx + PI_W'(1);
        end
        S_GAP:   r_gap <= r_gap + GAP_W'(1);
        default: ;
      endcase
    end
  end

  assign busy_o = (r_state != S_IDLE);
  assign data_o = (r_state == S_SEND) ? w_byte : r_last;
endmodule

// File: tb/tb_serial_out_frame_sequencer.sv
// Bench for serial_out_frame_sequencer: three instances (BYTE_GAP 2/1/4) share stimulus;
// ticks and done pulses are logged per instance and compared against hand-derived values.
module tb_serial_out_frame_sequencer;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_we, freq_we, frame_start;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_pattern, freq_pattern;
  logic [2:0]  cfg_ctrl;
  logic [7:0]  slow_p, fast_p;
  logic        busy [3];
  logic        done [3];
  logic        tick [3];
  logic [7:0]  dat  [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n  [3];
  int dn [3];
  int tc [3][400];
  logic [7:0] td [3][400];
  int dcyc [3][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar gi = 0; gi < 3; gi++) begin : gen_dut
    serial_out_frame_sequencer #(.BYTE_GAP(gi == 0 ? 2 : (gi == 1 ? 1 : 4))) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
      .cfg_pattern_i(cfg_pattern), .cfg_ctrl_i(cfg_ctrl), .freq_we_i(freq_we),
      .freq_pattern_i(freq_pattern), .slow_period_i(slow_p), .fast_period_i(fast_p),
      .frame_start_i(frame_start), .busy_o(busy[gi]), .frame_done_tick_o(done[gi]),
      .data_o(dat[gi]), .tick_o(tick[gi]));
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (tick[i]) begin
        if (n[i] < 400) begin tc[i][n[i]] = cyc; td[i][n[i]] = dat[i]; end
        n[i]++;
      end
      if (done[i]) begin
        if (dn[i] < 4) dcyc[i][dn[i]] = cyc;
        dn[i]++;
      end
    end
  end

  function automatic int gap_of(int i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic step(int k = 1);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic clr_log();
    for (int i = 0; i < 3; i++) begin n[i] = 0; dn[i] = 0; end
  endtask

  task automatic start_frame(output int c0);
    c0 = cyc;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int k;
    for (k = 0; k < bound; k++) begin
      if (!busy[0] && !busy[1] && !busy[2]) break;
      step();
    end
    chk("idle_timeout", int'(k < bound), 1);
    step(2);
  endtask

  task automatic cfg_write(logic [3:0] ch, logic [31:0] pat, logic [2:0] ctrl);
    cfg_addr = ch; cfg_pattern = pat; cfg_ctrl = ctrl; cfg_we = 1'b1;
    step();
    cfg_we = 1'b0;
  endtask

  task automatic chk_timing(int c0);
    for (int i = 0; i < 3; i++) begin
      int g, bad;
      g = gap_of(i);
      bad = 0;
      for (int k = 0; k < 152; k++)
        if (tc[i][k+1] - tc[i][k] != ((k % 9 == 8) ? g + 1 : g)) bad++;
      chk($sformatf("ticks_n[%0d]", i), n[i], 153);
      chk($sformatf("done_n[%0d]", i), dn[i], 1);
      chk($sformatf("first_tick[%0d]", i), tc[i][0], c0 + 2);
      chk($sformatf("spacing_bad[%0d]", i), bad, 0);
      chk($sformatf("frame_len[%0d]", i), tc[i][152] - tc[i][0], 17*8*g + 16*(g+1));
      chk($sformatf("done_cyc[%0d]", i), dcyc[i][0], tc[i][152] + 1);
    end
  endtask

  typedef struct {
    logic [3:0]  ch;
    logic [31:0] pat;
    logic [2:0]  ctrl;
    logic [7:0]  exp_sel;
  } vec_t;

  initial begin
    vec_t vt [4];
    logic [7:0] fexp [9];
    logic [7:0] e;
    int c0, base;
    vt[0] = '{4'd3,  32'hA5A5_0F0F, 3'b101, 8'h3A};
    vt[1] = '{4'd0,  32'h1234_5678, 3'b111, 8'h0E};
    vt[2] = '{4'd15, 32'hDEAD_BEEF, 3'b010, 8'hF4};
    vt[3] = '{4'd7,  32'h0000_0001, 3'b001, 8'h72};

    rst_n = 1'b0; cfg_we = 0; freq_we = 0; frame_start = 0;
    cfg_addr = 0; cfg_pattern = 0; cfg_ctrl = 0; freq_pattern = 0; slow_p = 0; fast_p = 0;
    clr_log();
    step(3);
    chk("rst_busy", busy[0], 0);
    chk("rst_tick", tick[0], 0);
    chk("rst_data", dat[0], 0);
    chk("rst_done", done[0], 0);
    rst_n = 1'b1;
    step(2);

    // Frame with reset defaults.
    clr_log();
    start_frame(c0);
    chk("busy_n1", busy[0], 1);
    step();
    chk("tick_n2", tick[0], 1);
    chk("data_n2", dat[0], 8'h0A);
    wait_idle(2000);
    chk_timing(c0);
    fexp = '{8'h0A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h14, 8'h05, 8'h00, 8'h00};
    for (int k = 0; k < 9; k++) chk($sformatf("freq_def_b%0d", k), td[0][k], fexp[k]);

    // Table-driven channel writes; freq write coincides with the first cfg write.
    freq_pattern = 32'h1122_3344; slow_p = 8'h30; fast_p = 8'h07; freq_we = 1'b1;
    for (int v = 0; v < 4; v++) begin
      cfg_write(vt[v].ch, vt[v].pat, vt[v].ctrl);
      freq_we = 1'b0;
    end
    clr_log();
    start_frame(c0);
    wait_idle(2000);
    fexp = '{8'h0A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h30, 8'h07, 8'h00, 8'h00};
    for (int k = 0; k < 9; k++) chk($sformatf("freq_wr_b%0d", k), td[0][k], fexp[k]);
    for (int v = 0; v < 4; v++) begin
      base = (int'(vt[v].ch) + 1) * 9;
      for (int k = 0; k < 9; k++) begin
        case (k)
          0: e = 8'h0B;
          1: e = vt[v].pat[31:24];
          2: e = vt[v].pat[23:16];
          3: e = vt[v].pat[15:8];
          4: e = vt[v].pat[7:0];
          5: e = vt[v].exp_sel;
          default: e = 8'h00;
        endcase
        chk($sformatf("ch%0d_b%0d", vt[v].ch, k), td[0][base+k], e);
      end
    end
    chk("ticks_total", n[0], 153);

    // ch0 rewritten during its own LOAD cycle (c0+20 for BYTE_GAP=2).
    clr_log();
    start_frame(c0);
    step(19);
    chk("load_cyc", cyc, c0 + 20);
    cfg_write(4'd0, 32'hCAFE_F00D, 3'b000);
    wait_idle(2000);
    chk("ld_old_b1", td[0][10], 8'h12);
    chk("ld_old_b4", td[0][13], 8'h78);
    chk("ld_old_sel", td[0][14], 8'h0E);
    clr_log();
    start_frame(c0);
    wait_idle(2000);
    chk("ld_new_b1", td[0][10], 8'hCA);
    chk("ld_new_b4", td[0][13], 8'h0D);
    chk("ld_new_sel", td[0][14], 8'h00);

    // Three mid-frame start pulses merge into one pending frame.
    clr_log();
    start_frame(c0);
    step(20);
    repeat (3) begin
      frame_start = 1'b1; step(); frame_start = 1'b0; step(15);
    end
    wait_idle(4000);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("pend_done[%0d]", i), dn[i], 2);
      chk($sformatf("pend_ticks[%0d]", i), n[i], 306);
      chk($sformatf("pend_start[%0d]", i), tc[i][153], dcyc[i][0] + 2);
    end
    chk("pend_b0", td[0][153], 8'h0A);

    // Asynchronous reset in the middle of a DATA packet.
    clr_log();
    start_frame(c0);
    step(50);
    chk("pre_rst_busy", busy[0], 1);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy[0], 0);
    chk("arst_tick", tick[0], 0);
    chk("arst_data", dat[0], 0);
    chk("arst_done", done[0], 0);
    step(2);
    rst_n = 1'b1;
    step(2);
    clr_log();
    start_frame(c0);
    wait_idle(2000);
    chk("post_rst_ticks", n[0], 153);
    chk("post_rst_done", dn[0], 1);
    chk("post_rst_slow", td[0][5], 8'h14);
    chk("post_rst_ch3sel", td[0][41], 8'h30);
    chk("post_rst_ch3pat", td[0][37], 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
